// File: rtl/sd_start_conditioner_pkg.sv
// Shared definitions for the SD start conditioner: FSM encoding and default timing constants.
// The SD top uses the same defaults so both sides agree on debounce and timeout windows.
package sd_start_conditioner_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StFire = 2'd1,
        StWait = 2'd2
    } sd_state_e;

    localparam int unsigned DefDebounceCycles = 4;
    localparam int unsigned DefTimeoutCycles  = 16;
    localparam int unsigned DefCntW           = 8;

endpackage

// File: rtl/sd_start_conditioner_if.sv
// Button/start/finish signal bundle between the start conditioner and its neighbours.
// The master side is the conditioner; the slave side is the button source and SD.
interface sd_start_conditioner_if;

    logic btn_raw;
    logic fin;
    logic xs;
    logic busy;
    logic btn_clean;
    logic overrun;
    logic timeout;

    modport master (
        input  btn_raw,
        input  fin,
        output xs,
        output busy,
        output btn_clean,
        output overrun,
        output timeout
    );

    modport slave (
        output btn_raw,
        output fin,
        input  xs,
        input  busy,
        input  btn_clean,
        input  overrun,
        input  timeout
    );

endinterface

// File: rtl/sd_sync_debounce.sv
// Two-flop synchronizer followed by a counting debouncer for the raw push-button.
// btn_clean only flips once the synced level has disagreed with it for DEBOUNCE_CYCLES cycles.
module sd_sync_debounce
    import sd_start_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned CNT_W           = DefCntW
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_clean
);

    logic             sync1_q;
    logic             btn_s_q;
    logic             btn_clean_q, btn_clean_d;
    logic [CNT_W-1:0] dcnt_q, dcnt_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q     <= 1'b0;
            btn_s_q     <= 1'b0;
            btn_clean_q <= 1'b0;
            dcnt_q      <= '0;
        end else begin
            sync1_q     <= btn_raw;
            btn_s_q     <= sync1_q;
            btn_clean_q <= btn_clean_d;
            dcnt_q      <= dcnt_d;
        end
    end

    // Any agreeing sample restarts the count, so short bounces never reach the threshold.
    always_comb begin
        btn_clean_d = btn_clean_q;
        dcnt_d      = '0;
        if (btn_s_q != btn_clean_q) begin
            if (dcnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                btn_clean_d = btn_s_q;
            end else begin
                dcnt_d = dcnt_q + CNT_W'(1);
            end
        end
    end

    assign btn_clean = btn_clean_q;

endmodule

// File: rtl/sd_start_conditioner.sv
// Front end of the SD sequencer: debounced button press -> single-cycle xs, held busy until fin,
// with overrun reporting for dropped presses and a timeout when fin never arrives.
module sd_start_conditioner
    import sd_start_conditioner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
    parameter int unsigned TIMEOUT_CYCLES  = DefTimeoutCycles,
    parameter int unsigned CNT_W           = DefCntW
) (
    input logic                    clk,
    input logic                    reset,
    sd_start_conditioner_if.master bus
);

    logic             btn_clean;
    logic             btn_clean_prev_q;
    logic             press;
    sd_state_e        state_q, state_d;
    logic [CNT_W-1:0] tcnt_q, tcnt_d;
    logic             overrun_q, overrun_d;
    logic             timeout_q, timeout_d;

    sd_sync_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_sync_debounce (
        .clk       (clk),
        .reset     (reset),
        .btn_raw   (bus.btn_raw),
        .btn_clean (btn_clean)
    );

    assign press = btn_clean & ~btn_clean_prev_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            btn_clean_prev_q <= 1'b0;
            state_q          <= StIdle;
            tcnt_q           <= '0;
            overrun_q        <= 1'b0;
            timeout_q        <= 1'b0;
        end else begin
            btn_clean_prev_q <= btn_clean;
            state_q          <= state_d;
            tcnt_q           <= tcnt_d;
            overrun_q        <= overrun_d;
            timeout_q        <= timeout_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        tcnt_d    = tcnt_q;
        timeout_d = 1'b0;
        overrun_d = press & (state_q != StIdle);
        case (state_q)
            StIdle: begin
                if (press) state_d = StFire;
            end
            StFire: begin
                state_d = StWait;
                tcnt_d  = '0;
            end
            StWait: begin
                tcnt_d = tcnt_q + CNT_W'(1);
                // fin takes priority over a coincident expiry.
                if (bus.fin) begin
                    state_d = StIdle;
                end else if (TIMEOUT_CYCLES != 0 &&
                             tcnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.xs        = (state_q == StFire);
    assign bus.busy      = (state_q != StIdle);
    assign bus.btn_clean = btn_clean;
    assign bus.overrun   = overrun_q;
    assign bus.timeout   = timeout_q;

endmodule
